// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN layer engines (pooling, conv, upsample).
// Contents: DRAM region bases, parameter-word count, one-hot engine states,
// fmap address packing and parameter range check.
package cnn_pkg;

  localparam int PARAM_BASE = 0;
  localparam int IFMAP_BASE = 65536;
  localparam int OFMAP_BASE = 131072;
  localparam int NUM_PARAM  = 3;
  localparam int DIM_MAX    = 16;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_LD_PARAM = 4'b0010,
    ST_UPSAMPLE = 4'b0100,
    ST_DONE     = 4'b1000
  } state_t;

  // Word offset of pixel (x,y,z) inside an fmap region: {z[3:0], y[4:0], x[4:0]}.
  function automatic logic [13:0] fmap_offset(input logic [5:0] x,
                                               input logic [5:0] y,
                                               input logic [5:0] z);
    return {z[3:0], y[4:0], x[4:0]};
  endfunction

  // A dimension is usable when it is 1..DIM_MAX.
  function automatic logic dim_ok(input logic [5:0] v);
    return (v != 6'd0) && (v <= 6'(DIM_MAX));
  endfunction

endpackage

// File: rtl/fmap_xyz_counter.sv
// Raster-order (x fastest, then y, then z) fmap coordinate counter.
// Ports:
//   clk, srst      clock, synchronous active-high reset
//   step           advance one pixel
//   clr            return to (0,0,0); wins over step
//   w, h, d        fmap dimensions
//   x, y, z        current coordinate
//   last           current coordinate is (w-1, h-1, d-1)
module fmap_xyz_counter (
  input  logic       clk,
  input  logic       srst,
  input  logic       step,
  input  logic       clr,
  input  logic [5:0] w,
  input  logic [5:0] h,
  input  logic [5:0] d,
  output logic [5:0] x,
  output logic [5:0] y,
  output logic [5:0] z,
  output logic       last
);

  logic x_wrap;
  logic y_wrap;

  assign x_wrap = (x == w - 6'd1);
  assign y_wrap = (y == h - 6'd1);
  assign last   = x_wrap && y_wrap && (z == d - 6'd1);

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      x <= '0;
      y <= '0;
      z <= '0;
    end else if (step) begin
      if (!x_wrap) begin
        x <= x + 6'd1;
      end else begin
        x <= '0;
        if (!y_wrap) begin
          y <= y + 6'd1;
        end else begin
          y <= '0;
          z <= z + 6'd1;
        end
      end
    end
  end

endmodule

// File: rtl/nn_upsample.sv
// Nearest-neighbour 2x upsampling engine: reads a pooled fmap from DRAM and
// writes each source pixel to a 2x2 block of the destination fmap.
// Ports:
//   clk, srst            clock, synchronous active-high reset
//   enable               start request (sampled in IDLE only)
//   data_in              DRAM read data, valid RD_LAT cycles after a read issue
//   addr_in, dram_en_rd  DRAM read address / strobe (decoded from state)
//   addr_out, data_out,
//   dram_en_wr           DRAM write address / data / strobe (registered)
//   done                 1-cycle pulse at end of layer
//
// state        | meaning
// ST_IDLE      | waiting for enable
// ST_LD_PARAM  | reading W/H/D words, 3+RD_LAT cycles
// ST_UPSAMPLE  | 4-cycle slots: read pixel n at s=0, write pixel n-1 at s=0..3
// ST_DONE      | one cycle, raises done for the following cycle
module nn_upsample #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int RD_LAT     = 1,
  parameter int SRC_BASE   = cnn_pkg::IFMAP_BASE,
  parameter int DST_BASE   = cnn_pkg::OFMAP_BASE,
  parameter int PARAM_BASE = cnn_pkg::PARAM_BASE
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic                  done
);

  import cnn_pkg::*;

  localparam logic [2:0] PC_LAST = 3'(NUM_PARAM + RD_LAT - 1);
  localparam logic [1:0] CAP_S   = 2'(RD_LAT);

  state_t                state;
  logic [2:0]            pc;
  logic [1:0]            s;
  logic [5:0]            w, h, d;
  logic                  first_slot;
  logic                  drain;
  logic [DATA_WIDTH-1:0] cap;
  logic [DATA_WIDTH-1:0] wdata;
  logic [5:0]            wx, wy, wz;
  logic [5:0]            x, y, z;
  logic                  last;
  logic                  cnt_step;
  logic                  cnt_clr;
  logic                  rd_par;
  logic                  rd_src;
  logic [13:0]           src_off;
  logic [13:0]           dst_off;

  // The counter tracks the pixel being read; it holds on the last pixel so
  // the drain slot can still latch its coordinates for the final writes.
  assign cnt_clr  = (state != ST_UPSAMPLE);
  assign cnt_step = (state == ST_UPSAMPLE) && (s == 2'd3) && !drain && !last;

  fmap_xyz_counter u_xyz (
    .clk  (clk),
    .srst (srst),
    .step (cnt_step),
    .clr  (cnt_clr),
    .w    (w),
    .h    (h),
    .d    (d),
    .x    (x),
    .y    (y),
    .z    (z),
    .last (last)
  );

  assign rd_par     = (state == ST_LD_PARAM) && (pc < 3'(NUM_PARAM));
  assign rd_src     = (state == ST_UPSAMPLE) && (s == 2'd0) && !drain;
  assign dram_en_rd = rd_par || rd_src;

  assign src_off = fmap_offset(x, y, z);
  // Sub-slot s picks the 2x2 corner: s[0] is dx, s[1] is dy.
  assign dst_off = fmap_offset({wx[4:0], s[0]}, {wy[4:0], s[1]}, wz);

  always_comb begin
    addr_in = '0;
    if (rd_par) begin
      addr_in = ADDR_WIDTH'(PARAM_BASE) + ADDR_WIDTH'(pc);
    end else if (rd_src) begin
      addr_in = ADDR_WIDTH'(SRC_BASE) + ADDR_WIDTH'(src_off);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state      <= ST_IDLE;
      pc         <= '0;
      s          <= '0;
      w          <= '0;
      h          <= '0;
      d          <= '0;
      first_slot <= 1'b0;
      drain      <= 1'b0;
      cap        <= '0;
      wdata      <= '0;
      wx         <= '0;
      wy         <= '0;
      wz         <= '0;
      data_out   <= '0;
      addr_out   <= '0;
      dram_en_wr <= 1'b0;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      dram_en_wr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state <= ST_LD_PARAM;
            pc    <= '0;
          end
        end
        ST_LD_PARAM: begin
          pc <= pc + 3'd1;
          if (pc == 3'(RD_LAT))     w <= data_in[5:0];
          if (pc == 3'(RD_LAT + 1)) h <= data_in[5:0];
          if (pc == PC_LAST) begin
            // Depth arrives on data_in in this very cycle, so it is checked live.
            d          <= data_in[5:0];
            s          <= '0;
            first_slot <= 1'b1;
            drain      <= 1'b0;
            if (dim_ok(w) && dim_ok(h) && dim_ok(data_in[5:0])) begin
              state <= ST_UPSAMPLE;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_UPSAMPLE: begin
          s <= s + 2'd1;
          if (s == CAP_S) cap <= data_in;
          if (!first_slot) begin
            dram_en_wr <= 1'b1;
            data_out   <= wdata;
            addr_out   <= ADDR_WIDTH'(DST_BASE) + ADDR_WIDTH'(dst_off);
          end
          if (s == 2'd3) begin
            // Hand the pixel just read to the write side for the next slot;
            // bypass cap when the read lands in this same cycle.
            first_slot <= 1'b0;
            wdata      <= (s == CAP_S) ? data_in : cap;
            wx         <= x;
            wy         <= y;
            wz         <= z;
            if (last)  drain <= 1'b1;
            if (drain) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_upsample.sv
module tb_nn_upsample;

  localparam int SRC = 65536;
  localparam int DST = 131072;

  logic        clk = 1'b0;
  logic        srst;
  logic        clr_mon;
  logic        en   [2];
  logic [31:0] din  [2];
  logic [31:0] dout [2];
  logic [17:0] ain  [2];
  logic [17:0] aout [2];
  logic        rd   [2];
  logic        wr   [2];
  logic        done [2];

  nn_upsample #(.RD_LAT(1)) u_dut_l1 (
    .clk(clk), .srst(srst), .enable(en[0]), .data_in(din[0]), .data_out(dout[0]),
    .addr_in(ain[0]), .addr_out(aout[0]), .dram_en_rd(rd[0]), .dram_en_wr(wr[0]),
    .done(done[0])
  );

  nn_upsample #(.RD_LAT(3)) u_dut_l3 (
    .clk(clk), .srst(srst), .enable(en[1]), .data_in(din[1]), .data_out(dout[1]),
    .addr_in(ain[1]), .addr_out(aout[1]), .dram_en_rd(rd[1]), .dram_en_wr(wr[1]),
    .done(done[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DRAM model ----------------
  int          cfg_w, cfg_h, cfg_d;
  logic [31:0] pword   [3];
  logic [31:0] src_mem [16384];
  logic [31:0] pipe    [2][3];

  function automatic logic [31:0] mem_rd(input logic [17:0] a);
    if (int'(a) < 3) return pword[a[1:0]];
    if (int'(a) >= SRC && int'(a) < SRC + 16384) return src_mem[int'(a) - SRC];
    return 32'hBADA_DD00;
  endfunction

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      pipe[g][0] <= rd[g] ? mem_rd(ain[g]) : $urandom;
      pipe[g][1] <= pipe[g][0];
      pipe[g][2] <= pipe[g][1];
    end
  end
  assign din[0] = pipe[0][0];
  assign din[1] = pipe[1][2];

  // ---------------- reference model ----------------
  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic int n_pix();
    return cfg_w * cfg_h * cfg_d;
  endfunction

  // k-th write: source pixel n = k/4 in raster order, corner j = k%4 with dx = j%2, dy = j/2.
  function automatic logic [17:0] exp_waddr(input int k);
    int n, j, x, y, z;
    n = k / 4; j = k % 4;
    x = n % cfg_w; y = (n / cfg_w) % cfg_h; z = n / (cfg_w * cfg_h);
    return 18'(DST + z * 1024 + (2 * y + j / 2) * 32 + 2 * x + j % 2);
  endfunction

  function automatic logic [31:0] exp_wdata(input int k);
    int n, x, y, z;
    n = k / 4;
    x = n % cfg_w; y = (n / cfg_w) % cfg_h; z = n / (cfg_w * cfg_h);
    return src_mem[z * 1024 + y * 32 + x];
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int          wr_cnt [2], nbad [2], oob [2], done_cnt [2], done_cyc [2];
  int          last_wr_cyc [2], rd_cnt [2], par_rd [2], bad_rd [2];
  logic [17:0] last_wa [2];
  logic [31:0] dimg [2][128];

  always @(negedge clk) begin
    if (clr_mon) begin
      for (int g = 0; g < 2; g++) begin
        wr_cnt[g] <= 0; nbad[g] <= 0; oob[g] <= 0; done_cnt[g] <= 0; done_cyc[g] <= 0;
        last_wr_cyc[g] <= 0; rd_cnt[g] <= 0; par_rd[g] <= 0; bad_rd[g] <= 0;
        last_wa[g] <= '0;
        for (int i = 0; i < 128; i++) dimg[g][i] <= '0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (wr[g]) begin
          if (int'(aout[g]) < DST || int'(aout[g]) >= DST + 16384) oob[g] <= oob[g] + 1;
          if (wr_cnt[g] >= 4 * n_pix() || aout[g] !== exp_waddr(wr_cnt[g]) ||
              dout[g] !== exp_wdata(wr_cnt[g]))
            nbad[g] <= nbad[g] + 1;
          if (int'(aout[g]) >= DST && int'(aout[g]) < DST + 128)
            dimg[g][int'(aout[g]) - DST] <= dout[g];
          last_wa[g]     <= aout[g];
          last_wr_cyc[g] <= cyc;
          wr_cnt[g]      <= wr_cnt[g] + 1;
        end
        if (rd[g]) begin
          rd_cnt[g] <= rd_cnt[g] + 1;
          if (int'(ain[g]) < 3) par_rd[g] <= par_rd[g] + 1;
          else if (int'(ain[g]) < SRC || int'(ain[g]) >= SRC + 16384) bad_rd[g] <= bad_rd[g] + 1;
        end
        if (done[g]) begin
          done_cnt[g] <= done_cnt[g] + 1;
          done_cyc[g] <= cyc;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input int g, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s [rd_lat=%0d]: got %0d, want %0d", tag, lat_of(g), obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setup(input int w, input int h, input int d);
    logic [31:0] r;
    cfg_w = w; cfg_h = h; cfg_d = d;
    r = $urandom; pword[0] = {r[31:6], 6'(w)};
    r = $urandom; pword[1] = {r[31:6], 6'(h)};
    r = $urandom; pword[2] = {r[31:6], 6'(d)};
    for (int i = 0; i < 16384; i++) src_mem[i] = $urandom;
    clr_mon = 1'b1;
    tick(1);
    clr_mon = 1'b0;
  endtask

  task automatic start_pulse(output int t0);
    t0 = cyc;
    en[0] = 1'b1; en[1] = 1'b1;
    tick(1);
    en[0] = 1'b0; en[1] = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while ((done_cnt[0] == 0 || done_cnt[1] == 0) && c < budget) begin
      tick(1);
      c++;
    end
    tick(3);
  endtask

  task automatic check_run(input string tag, input int t0, input logic valid);
    int n, lat;
    for (int g = 0; g < 2; g++) begin
      n   = valid ? n_pix() : 0;
      lat = lat_of(g);
      check({tag, " done pulses"}, g, done_cnt[g], 1);
      check({tag, " enable-to-done cycles"}, g, done_cyc[g] - t0,
            5 + lat + (valid ? 4 * (n + 1) : 0));
      check({tag, " write count"}, g, wr_cnt[g], 4 * n);
      check({tag, " param reads"}, g, par_rd[g], 3);
      check({tag, " total reads"}, g, rd_cnt[g], 3 + n);
      check({tag, " stray reads"}, g, bad_rd[g], 0);
      if (valid) begin
        check({tag, " write mismatches"}, g, nbad[g], 0);
        check({tag, " out-of-region writes"}, g, oob[g], 0);
        check({tag, " done after last write"}, g, done_cyc[g] - last_wr_cyc[g], 1);
        check({tag, " last write addr"}, g, last_wa[g], exp_waddr(4 * n - 1));
      end
    end
  endtask

  task automatic run_221(input string tag);
    int t0;
    setup(2, 2, 1);
    src_mem[0] = 32'd1; src_mem[1] = 32'd2; src_mem[32] = 32'd3; src_mem[33] = 32'd4;
    start_pulse(t0);
    wait_done(100);
    check_run(tag, t0, 1'b1);
    for (int g = 0; g < 2; g++) begin
      check({tag, " last addr"}, g, last_wa[g], DST + 3 * 32 + 3);
      for (int yy = 0; yy < 4; yy++)
        for (int xx = 0; xx < 4; xx++)
          check($sformatf("%s dst(%0d,%0d)", tag, xx, yy), g, dimg[g][yy * 32 + xx],
                1 + xx / 2 + 2 * (yy / 2));
    end
  endtask

  task automatic run_layer(input string tag, input int w, input int h, input int d,
                           input logic valid);
    int t0;
    setup(w, h, d);
    start_pulse(t0);
    wait_done(valid ? 4 * (w * h * d + 1) + 40 : 40);
    check_run(tag, t0, valid);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, c, w, h, d, wsnap[2], rsnap[2];
    srst = 1'b1; clr_mon = 1'b1; en[0] = 1'b0; en[1] = 1'b0;
    tick(3);
    for (int g = 0; g < 2; g++) begin
      check("reset dram_en_rd", g, rd[g], 0);
      check("reset dram_en_wr", g, wr[g], 0);
      check("reset done", g, done[g], 0);
      check("reset addr_in", g, ain[g], 0);
      check("reset addr_out", g, aout[g], 0);
      check("reset data_out", g, dout[g], 0);
    end
    srst = 1'b0; clr_mon = 1'b0;
    tick(2);

    run_221("p221");
    run_layer("p0_4_4", 0, 4, 4, 1'b0);
    run_layer("p17_2_1", 17, 2, 1, 1'b0);
    run_layer("p16_1_1", 16, 1, 1, 1'b1);
    run_layer("p1_16_2", 1, 16, 2, 1'b1);
    run_layer("p1_1_1", 1, 1, 1, 1'b1);

    for (int r = 0; r < 4; r++) begin
      w = $urandom_range(1, 5); h = $urandom_range(1, 5); d = $urandom_range(1, 4);
      run_layer($sformatf("rand%0d_%0dx%0dx%0d", r, w, h, d), w, h, d, 1'b1);
    end
    run_layer("rand_bad_depth", $urandom_range(1, 16), $urandom_range(1, 16),
              $urandom_range(17, 63), 1'b0);

    run_layer("p16_16_16", 16, 16, 16, 1'b1);

    // Reset in the middle of UPSAMPLE, then a clean run.
    setup(4, 4, 2);
    start_pulse(t0);
    c = 0;
    while (wr_cnt[1] < 5 && c < 300) begin tick(1); c++; end
    check("rst writes before abort", 1, (wr_cnt[1] >= 5) ? 1 : 0, 1);
    srst = 1'b1;
    tick(1);
    for (int g = 0; g < 2; g++) begin
      check("rst dram_en_rd after srst", g, rd[g], 0);
      check("rst dram_en_wr after srst", g, wr[g], 0);
      check("rst done after srst", g, done[g], 0);
      wsnap[g] = wr_cnt[g]; rsnap[g] = rd_cnt[g];
    end
    srst = 1'b0;
    tick(20);
    for (int g = 0; g < 2; g++) begin
      check("rst no writes after abort", g, wr_cnt[g], wsnap[g]);
      check("rst no reads after abort", g, rd_cnt[g], rsnap[g]);
      check("rst no done after abort", g, done_cnt[g], 0);
    end
    run_221("after_rst_221");

    // Enable held high through the run; dropped in the done cycle.
    setup(3, 2, 2);
    t0 = cyc;
    en[0] = 1'b1; en[1] = 1'b1;
    c = 0;
    while ((en[0] || en[1]) && c < 4 * 13 + 60) begin
      @(negedge clk);
      if (done[0]) en[0] = 1'b0;
      if (done[1]) en[1] = 1'b0;
      c++;
    end
    en[0] = 1'b0; en[1] = 1'b0;
    tick(5);
    check_run("held_enable", t0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
